// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX byte stream; a grant lasts until tlast or MAX_BURST beats.
// Owner data passes through combinationally; arbitration costs one idle cycle; non-owners see tready=0.
module uart_tx_arbiter #(
   parameter int N_PORTS   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*N_PORTS-1:0]   s_axis_tdata,
   input  logic [N_PORTS-1:0]     s_axis_tvalid,
   input  logic [N_PORTS-1:0]     s_axis_tlast,
   output logic [N_PORTS-1:0]     s_axis_tready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [N_PORTS-1:0]     grant,
   output logic                   busy,
   output logic                   force_rel
);

   localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] last_owner, owner, pick_idx, cand;
   logic          pick_vld;
   logic [7:0]    beat_cnt, cnt_inc;
   logic          beat_done, owner_last, at_limit, release_now;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = IW'((int'(last_owner) + k) % N_PORTS);
         if (!pick_vld && s_axis_tvalid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign m_axis_tdata  = s_axis_tdata[8*owner +: 8];
   assign m_axis_tvalid = (state == LOCK) && s_axis_tvalid[owner];
   assign s_axis_tready = ((state == LOCK) && m_axis_tready) ? grant : '0;

   assign beat_done   = m_axis_tvalid && m_axis_tready;
   assign owner_last  = s_axis_tlast[owner];
   assign cnt_inc     = beat_cnt + 8'd1;
   assign at_limit    = (cnt_inc == 8'(MAX_BURST));
   assign release_now = beat_done && (owner_last || at_limit);
   assign busy        = (state == LOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld)    state_nxt = LOCK;
         LOCK:    if (release_now) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= '0;
         owner      <= '0;
         last_owner <= IW'(N_PORTS - 1);
         beat_cnt   <= '0;
         force_rel  <= 1'b0;
      end else begin
         force_rel <= 1'b0;
         if (state == IDLE) begin
            if (pick_vld) begin
               grant    <= N_PORTS'(1) << pick_idx;
               owner    <= pick_idx;
               beat_cnt <= '0;
            end
         end else if (beat_done) begin
            beat_cnt <= cnt_inc;
            if (release_now) begin
               grant      <= '0;
               last_owner <= owner;
               // A limit hit that coincides with tlast is an ordinary end of message.
               force_rel  <= !owner_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted byte sources per port, a beat monitor and hand-computed expectations.
module tb_uart_tx_arbiter;

   localparam int NP = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [8*NP-1:0] s_axis_tdata;
   logic [NP-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [7:0]      m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tready;
   logic [NP-1:0]   grant;
   logic            busy, force_rel;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_PORTS(NP), .MAX_BURST(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .grant         (grant),
      .busy          (busy),
      .force_rel     (force_rel)
   );

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   int cyc_n = 0;

   logic [7:0] src_dat  [NP][32];
   logic       src_last [NP][32];
   int         src_wr [NP];
   int         src_rd [NP];

   logic [7:0]    obs_dat[$];
   logic [NP-1:0] obs_gnt[$];
   int            obs_cyc[$];
   int            fr_cyc[$];
   logic          busy_hist[$];
   logic [NP-1:0] gnt_hist[$];
   logic [7:0]    exp_dat[$];
   logic [NP-1:0] exp_gnt[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      obs_dat.delete(); obs_gnt.delete(); obs_cyc.delete(); fr_cyc.delete();
      busy_hist.delete(); gnt_hist.delete(); exp_dat.delete(); exp_gnt.delete();
      cyc_n = 0;
   endtask

   task automatic clear_src();
      for (int i = 0; i < NP; i++) begin
         src_wr[i] = 0;
         src_rd[i] = 0;
      end
   endtask

   task automatic push(input int p, input logic [7:0] d, input logic l);
      src_dat[p][src_wr[p]]  = d;
      src_last[p][src_wr[p]] = l;
      src_wr[p]++;
   endtask

   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         if (src_rd[i] < src_wr[i]) begin
            s_axis_tvalid[i]        = 1'b1;
            s_axis_tdata[8*i +: 8]  = src_dat[i][src_rd[i]];
            s_axis_tlast[i]         = src_last[i][src_rd[i]];
         end else begin
            s_axis_tvalid[i]        = 1'b0;
            s_axis_tdata[8*i +: 8]  = 8'h00;
            s_axis_tlast[i]         = 1'b0;
         end
      end
   endtask

   // One clock: drive at posedge+1, observe at negedge, retire accepted source bytes.
   task automatic cyc(input logic rdy);
      logic [NP-1:0] hs;
      m_axis_tready = rdy;
      drive();
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
         obs_dat.push_back(m_axis_tdata);
         obs_gnt.push_back(grant);
         obs_cyc.push_back(cyc_n);
      end
      if (force_rel) fr_cyc.push_back(cyc_n);
      busy_hist.push_back(busy);
      gnt_hist.push_back(grant);
      if ($countones(grant) > 1) viol++;
      if (!busy && m_axis_tvalid) viol++;
      if (busy && (s_axis_tready != (m_axis_tready ? grant : 4'b0000))) viol++;
      hs = s_axis_tvalid & s_axis_tready;
      cyc_n++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) if (hs[i]) src_rd[i]++;
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
   endtask

   task automatic do_reset();
      clear_src();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   task automatic cmp_beats(input string tag);
      chk({tag, "_count"}, obs_dat.size(), exp_dat.size());
      for (int i = 0; i < exp_dat.size(); i++) begin
         chk($sformatf("%s_dat[%0d]", tag, i), (i < obs_dat.size()) ? obs_dat[i] : 8'hxx, exp_dat[i]);
         chk($sformatf("%s_gnt[%0d]", tag, i), (i < obs_gnt.size()) ? obs_gnt[i] : 4'hx, exp_gnt[i]);
      end
   endtask

   initial begin
      rst_n         = 1'b1;
      m_axis_tready = 1'b1;
      s_axis_tdata  = 32'h44332211;
      s_axis_tvalid = 4'hf;
      s_axis_tlast  = 4'h0;
      clear_src();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_grant", grant, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_force_rel", force_rel, 1'b0);
      chk("rst_m_vld", m_axis_tvalid, 1'b0);
      chk("rst_s_rdy", s_axis_tready, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();

      // Single message from port 2.
      clear_obs();
      push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
      run(6);
      exp_dat = '{8'h41, 8'h42, 8'h43};
      exp_gnt = '{4'b0100, 4'b0100, 4'b0100};
      cmp_beats("single");
      chk("single_busy0", busy_hist[0], 1'b0);
      chk("single_busy1", busy_hist[1], 1'b1);
      chk("single_busy3", busy_hist[3], 1'b1);
      chk("single_busy4", busy_hist[4], 1'b0);
      chk("single_drained", src_rd[2], 3);

      // Round robin from reset.
      do_reset();
      clear_obs();
      push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
      push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
      run(12);
      exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      cmp_beats("rr");
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr_cyc[%0d]", i), (i < obs_cyc.size()) ? obs_cyc[i] : -1, 1 + 2*i);

      // Backpressure on a port 1 message.
      clear_obs();
      push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b0); push(1, 8'h24, 1'b1);
      begin
         logic rdy_pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
         for (int i = 0; i < 10; i++) cyc(rdy_pat[i]);
      end
      exp_dat = '{8'h21, 8'h22, 8'h23, 8'h24};
      exp_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
      cmp_beats("bp");
      chk("bp_cyc1", (obs_cyc.size() > 1) ? obs_cyc[1] : -1, 4);
      chk("bp_stall_gnt", gnt_hist[2], 4'b0010);

      // Forced release of port 3 while port 0 waits.
      clear_obs();
      for (int i = 0; i < 20; i++) push(3, 8'(8'h30 + i), 1'b0);
      push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1);
      run(30);
      for (int i = 0; i < 16; i++) begin exp_dat.push_back(8'(8'h30 + i)); exp_gnt.push_back(4'b1000); end
      exp_dat.push_back(8'h50); exp_gnt.push_back(4'b0001);
      exp_dat.push_back(8'h51); exp_gnt.push_back(4'b0001);
      for (int i = 16; i < 20; i++) begin exp_dat.push_back(8'(8'h30 + i)); exp_gnt.push_back(4'b1000); end
      cmp_beats("force");
      chk("force_pulses", fr_cyc.size(), 1);
      chk("force_pulse_cyc", (fr_cyc.size() > 0) ? fr_cyc[0] : -1, 17);
      chk("force_gnt_clear", gnt_hist[17], 4'b0000);
      chk("force_next_owner", gnt_hist[18], 4'b0001);
      chk("force_hold_gnt", grant, 4'b1000);
      chk("force_hold_busy", busy, 1'b1);

      // Limit coinciding with tlast.
      do_reset();
      clear_obs();
      for (int i = 0; i < 16; i++) push(0, 8'(8'h60 + i), (i == 15));
      run(20);
      for (int i = 0; i < 16; i++) begin exp_dat.push_back(8'(8'h60 + i)); exp_gnt.push_back(4'b0001); end
      cmp_beats("coinc");
      chk("coinc_no_force", fr_cyc.size(), 0);
      chk("coinc_gnt_clear", gnt_hist[17], 4'b0000);
      chk("coinc_busy_low", busy_hist[17], 1'b0);

      // Asynchronous reset in the middle of a port 1 message.
      clear_obs();
      push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
      run(2);
      m_axis_tready = 1'b1;
      drive();
      #2;
      chk("arst_pre_vld", m_axis_tvalid, 1'b1);
      chk("arst_pre_dat", m_axis_tdata, 8'h72);
      rst_n = 1'b0;
      #1;
      chk("arst_grant", grant, 4'b0000);
      chk("arst_m_vld", m_axis_tvalid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_s_rdy", s_axis_tready, 4'b0000);
      push(0, 8'h80, 1'b1);
      run(2);
      rst_n = 1'b1;
      clear_obs();
      run(10);
      exp_dat = '{8'h80, 8'h72, 8'h73};
      exp_gnt = '{4'b0001, 4'b0010, 4'b0010};
      cmp_beats("arst");

      chk("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_PORTS, 4, number of byte-stream requesters (2..8).
- MAX_BURST, 16, maximum beats per grant before forced release (1..255).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset, asynchronous assert, active-low.
- s_axis_tdata, in, 8*N_PORTS, byte from port i in bits [8i+7:8i].
- s_axis_tvalid, in, N_PORTS, per-port valid.
- s_axis_tlast, in, N_PORTS, per-port end-of-message marker.
- s_axis_tready, out, N_PORTS, per-port ready.
- m_axis_tdata, out, 8, byte to the UART transmitter.
- m_axis_tvalid, out, 1, valid to the UART transmitter.
- m_axis_tready, in, 1, ready from the UART transmitter.
- grant, out, N_PORTS, one-hot current owner; all zero when no port owns the transmitter.
- busy, out, 1, high while any port holds the grant.
- force_rel, out, 1, one-cycle pulse when a grant is released at MAX_BURST without tlast.

Function
REQ-003 The block SHALL implement a two-state FSM: IDLE and LOCK.

REQ-004 In IDLE with any s_axis_tvalid bit high, the block SHALL select the first requesting port in round-robin order, starting at last_owner+1 and wrapping modulo N_PORTS. On the next edge it SHALL load grant one-hot, clear the beat counter to 0, and enter LOCK.

REQ-005 In IDLE, the block SHALL hold m_axis_tvalid=0 and s_axis_tready all zero, so no beat transfers during arbitration. The minimum latency from s_axis_tvalid to m_axis_tvalid is 1 cycle.

REQ-006 In LOCK, with owner g:
- m_axis_tdata and m_axis_tvalid SHALL be combinationally equal to port g's tdata and tvalid.
- s_axis_tready[g] SHALL equal m_axis_tready.
- All other s_axis_tready bits SHALL be 0.

REQ-007 A beat SHALL complete only when m_axis_tvalid and m_axis_tready are both high on a rising edge. Each completed beat SHALL increment the 8-bit beat counter.

REQ-008 A completed beat with s_axis_tlast[g]=1 SHALL, on that edge, set last_owner=g, clear grant, and return to IDLE.

REQ-009 A completed beat without tlast that makes the counter equal MAX_BURST SHALL, on that edge, release the grant in the same way as REQ-008 and pulse force_rel high for exactly the next cycle.

REQ-010 If tlast and the MAX_BURST limit coincide on the same beat, the block SHALL treat it as a normal release, with no force_rel pulse.

REQ-011 In LOCK, the owner deasserting tvalid SHALL NOT release the grant. The block SHALL wait indefinitely for tlast or for MAX_BURST.

REQ-012 Requests arriving on other ports during LOCK SHALL be held off (tready=0) with no data loss. They SHALL be arbitrated in the first IDLE cycle after release.

REQ-013 busy SHALL be 1 exactly when the FSM is in LOCK.

REQ-014 The block SHALL produce grant, busy, force_rel, last_owner and the FSM state from flops, with no combinational path from s_axis_tvalid to grant.

REQ-015 At most one grant bit SHALL ever be high, and m_axis_tvalid SHALL never be high in IDLE.

Reset
REQ-016 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state to IDLE;
- grant to 0, busy to 0, force_rel to 0;
- beat counter to 0;
- last_owner to N_PORTS-1, so port 0 has first priority.

REQ-017 While in reset, the block SHALL drive m_axis_tvalid=0 and s_axis_tready all zero.

REQ-018 If reset is asserted mid-message, the block SHALL abandon the message: no further beats are forwarded, and arbitration restarts from port 0 after rst_n rises.

REQ-019 After rst_n rises, the block SHALL take its first action on the following rising clk edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N_PORTS=4, MAX_BURST=16):
- Single message: port 2 sends 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready=1 → m_axis_tdata sequence 0x41,0x42,0x43; grant=4'b0100 throughout; busy falls the cycle after 0x43.
- Round-robin: all four ports request from reset, each with a 1-byte message → grant order 0,1,2,3, then 0 again; one idle cycle between messages.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a port 1 message → no byte duplicated or dropped; s_axis_tready[1] mirrors m_axis_tready.
- Forced release: port 3 streams 20 bytes with no tlast → after byte 16, force_rel pulses once and grant clears; port 0 (also requesting) wins next; port 3 is served again afterwards.
- Coincident limit: port 0 sends 16 bytes with tlast on byte 16 → normal release, force_rel stays 0.
- Async reset: assert rst_n=0 mid-message at byte 2 of port 1 → grant=0 and m_axis_tvalid=0 before the next clk edge; after release, port 0 is served first if it requests.
